// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I datapath width and common constants
package rv32i_pkg;
    localparam int DPW = 32;
    localparam logic [DPW-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [DPW-1:0] FLUSH_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/fetch_stage_reg_if.sv
// fetch_stage_reg_if: hazard-control and next-PC bus into the fetch PC register
interface fetch_stage_reg_if;
    import rv32i_pkg::*;
    logic           flushF;
    logic           stallF;
    logic [DPW-1:0] PCNext;
    logic [DPW-1:0] PCF;
    modport master (output flushF, output stallF, output PCNext, input PCF);
    modport slave (input flushF, input stallF, input PCNext, output PCF);
endinterface

// File: rtl/pipe_reg_en_clr.sv
// pipe_reg_en_clr: pipeline register with sync reset, clear-to-constant and enable
module pipe_reg_en_clr #(
    parameter int W = 32,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    // clear outranks enable so a flush lands even while stalled
    always_comb q_d = clr ? CLR_VAL : (en ? d : q_q);

    always_ff @(posedge clk) begin
        if (rst) q_q <= RST_VAL;
        else     q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/fetch_stage_reg.sv
// fetch_stage_reg: IF-stage program-counter register with stall and flush control
module fetch_stage_reg
    import rv32i_pkg::*;
#(
    parameter logic [DPW-1:0] RESET_PC = RESET_VECTOR,
    parameter logic [DPW-1:0] FLUSH_PC = FLUSH_VECTOR
) (
    input logic              clk,
    input logic              rst,
    fetch_stage_reg_if.slave bus
);
    pipe_reg_en_clr #(
        .W(DPW),
        .RST_VAL(RESET_PC),
        .CLR_VAL(FLUSH_PC)
    ) u_pc (
        .clk(clk),
        .rst(rst),
        .clr(bus.flushF),
        .en(~bus.stallF),
        .d(bus.PCNext),
        .q(bus.PCF)
    );

`ifndef SYNTHESIS
    a_ctrl_known: assert property (@(posedge clk) !rst |-> !$isunknown({bus.flushF, bus.stallF}));
    a_stall_hold: assert property (@(posedge clk) (!rst && !bus.flushF && bus.stallF) |=> (bus.PCF == $past(bus.PCF)));
`endif
endmodule

// File: tb/tb_fetch_stage_reg.sv
// tb_fetch_stage_reg: directed and randomized checks of the fetch PC register against a priority model
module tb_fetch_stage_reg;
    logic        clk;
    logic        rst;
    logic        flush;
    logic        stall;
    logic [31:0] pc_next;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    int          checks;
    int          errors;

    localparam logic [31:0] RST_B = 32'h0000_1000;

    fetch_stage_reg_if bus_a ();
    fetch_stage_reg_if bus_b ();

    assign bus_a.flushF = flush;
    assign bus_a.stallF = stall;
    assign bus_a.PCNext = pc_next;
    assign bus_b.flushF = flush;
    assign bus_b.stallF = stall;
    assign bus_b.PCNext = pc_next;

    fetch_stage_reg dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    fetch_stage_reg #(.RESET_PC(RST_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] model(input logic [31:0] cur, input logic [31:0] rv,
                                          input logic r, input logic f, input logic s, input logic [31:0] p);
        if (r) return rv;
        if (f) return 32'h0;
        if (s) return cur;
        return p;
    endfunction

    task automatic drive(input logic r, input logic f, input logic s, input logic [31:0] p);
        rst = r;
        flush = f;
        stall = s;
        pc_next = p;
        exp_a = model(exp_a, 32'h0, r, f, s, p);
        exp_b = model(exp_b, RST_B, r, f, s, p);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h1234_5678);
        checks++;
        if (bus_a.PCF !== 32'h0) begin
            errors++;
            $display("FAIL reset_a got %h want %h", bus_a.PCF, 32'h0);
        end
        checks++;
        if (bus_b.PCF !== RST_B) begin
            errors++;
            $display("FAIL reset_b got %h want %h", bus_b.PCF, RST_B);
        end
    endtask

    task automatic test_load();
        logic [31:0] v [2] = '{32'h0000_0104, 32'h0000_0108};
        foreach (v[i]) begin
            drive(1'b0, 1'b0, 1'b0, v[i]);
            checks++;
            if (bus_a.PCF !== v[i]) begin
                errors++;
                $display("FAIL load%0d got %h want %h", i, bus_a.PCF, v[i]);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
            checks++;
            if (bus_a.PCF !== 32'h0000_0108) begin
                errors++;
                $display("FAIL stall_hold%0d got %h want %h", i, bus_a.PCF, 32'h0000_0108);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        checks++;
        if (bus_a.PCF !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL stall_release got %h want %h", bus_a.PCF, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_flush();
        drive(1'b0, 1'b1, 1'b0, 32'hCAFE_F00C);
        checks++;
        if (bus_a.PCF !== 32'h0) begin
            errors++;
            $display("FAIL flush got %h want %h", bus_a.PCF, 32'h0);
        end
        drive(1'b0, 1'b0, 1'b0, 32'hCAFE_F00C);
        checks++;
        if (bus_a.PCF !== 32'hCAFE_F00C) begin
            errors++;
            $display("FAIL flush_release got %h want %h", bus_a.PCF, 32'hCAFE_F00C);
        end
    endtask

    task automatic test_flush_stall();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b1, $urandom | 32'h4);
            checks++;
            if (bus_a.PCF !== 32'h0) begin
                errors++;
                $display("FAIL flush_stall%0d got %h want %h", i, bus_a.PCF, 32'h0);
            end
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b0, 1'b0, 1'b0, 32'h0000_2468);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_9999);
        checks++;
        if (bus_b.PCF !== RST_B) begin
            errors++;
            $display("FAIL rst_prio_b got %h want %h", bus_b.PCF, RST_B);
        end
        checks++;
        if (bus_a.PCF !== 32'h0) begin
            errors++;
            $display("FAIL rst_prio_a got %h want %h", bus_a.PCF, 32'h0);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] v [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        foreach (v[i]) begin
            drive(1'b0, 1'b0, 1'b0, v[i]);
            checks++;
            if (bus_a.PCF !== v[i]) begin
                errors++;
                $display("FAIL wrap%0d got %h want %h", i, bus_a.PCF, v[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) == 0, $urandom);
            checks++;
            if (bus_a.PCF !== exp_a) begin
                errors++;
                $display("FAIL rand_a%0d got %h want %h", i, bus_a.PCF, exp_a);
            end
            checks++;
            if (bus_b.PCF !== exp_b) begin
                errors++;
                $display("FAIL rand_b%0d got %h want %h", i, bus_b.PCF, exp_b);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        flush = 1'b0;
        stall = 1'b0;
        pc_next = 32'h1234_5678;
        exp_a = 32'h0;
        exp_b = RST_B;
        test_reset();
        test_load();
        test_stall();
        test_flush();
        test_flush_stall();
        test_reset_priority();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
